reg_write_arbiter: RTL and testbench

Round-robin write arbiter sharing a bank of 8-bit enable-gated registers between several requesters. Each requester presents a register address and data byte with a valid/ready handshake. The arbiter selects one winner per transfer and drives the target register's enable and data inputs for exactly one cycle. It sits between the requesting control blocks and the register bank, and is the only writer of that bank.

---
 rtl/reg_write_arbiter.sv | 170 +++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter that lets several requesters write a
// bank of 8-bit enable-gated registers, one transfer at a time. A winner is
// picked in IDLE and served for exactly one GRANT cycle; all outputs are
// registered.
// Optional feature: define REG_ARB_LOCK_EN to add the req_lock input, which
// lets the current winner keep the bank for consecutive rounds.
module reg_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 4,
    parameter int AW       = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*AW-1:0]      req_addr,
    input  logic [NUM_REQ*8-1:0]       req_data,
`ifdef REG_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]         req_lock,
`endif
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REGS-1:0]        reg_en,
    output logic [7:0]                 reg_d,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       addr_err
);

    localparam int          PW = $clog2(NUM_REQ);
    localparam int unsigned NR = NUM_REQ;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_rr_ptr;
    logic [PW-1:0]       r_grant_id;
    logic [NUM_REQ-1:0]  r_ready;
    logic [NUM_REGS-1:0] r_reg_en;
    logic [7:0]          r_reg_d;
    logic                r_busy;
    logic                r_addr_err;

    logic [PW-1:0]       w_start;
    logic [NUM_REQ-1:0]  w_cand;
    logic                w_found;
    logic [PW-1:0]       w_win;
    logic [PW-1:0]       w_grant_next;
    logic [AW-1:0]       w_addr;
    logic [7:0]          w_data;
    logic                w_addr_ok;
    logic [NUM_REQ-1:0]  w_ready_oh;
    logic [NUM_REGS-1:0] w_en_oh;

    // Explicit wrap so non-power-of-2 NUM_REQ never produces an out-of-range index
    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] v);
        if (int'(v) == NUM_REQ - 1) f_inc = '0;
        else                        f_inc = v + 1'b1;
    endfunction

    assign w_grant_next = f_inc(r_grant_id);

`ifdef REG_ARB_LOCK_EN
    logic r_lock;
    logic w_lock_keep;

    // A lock survives only while its owner is still requesting; otherwise the
    // search restarts just after the old owner.
    assign w_lock_keep = r_lock & req_valid[r_grant_id];
    assign w_start     = r_lock ? w_grant_next : r_rr_ptr;
    assign w_cand      = w_lock_keep ? (NUM_REQ'(1) << r_grant_id) : req_valid;
`else
    assign w_start     = r_rr_ptr;
    assign w_cand      = req_valid;
`endif

    // Round-robin search upward from w_start with wrap-around; first hit wins
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            logic [PW-1:0] idx;
            idx = PW'((k + w_start) % NR);
            if (!w_found && w_cand[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    assign w_addr    = req_addr[w_win*AW +: AW];
    assign w_data    = req_data[w_win*8 +: 8];
    assign w_addr_ok = (int'(w_addr) < NUM_REGS);

    // One-hot decodes of the winner and its target register
    always_comb begin
        w_ready_oh = '0;
        w_en_oh    = '0;
        for (int unsigned q = 0; q < NR; q++) begin
            w_ready_oh[q] = (int'(w_win) == q);
        end
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            w_en_oh[r] = (int'(w_addr) == r);
        end
    end

    // Arbitration FSM with registered handshake and bank-write outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_ready    <= '0;
            r_reg_en   <= '0;
            r_reg_d    <= 8'h00;
            r_busy     <= 1'b0;
            r_addr_err <= 1'b0;
`ifdef REG_ARB_LOCK_EN
            r_lock     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
`ifdef REG_ARB_LOCK_EN
                    if (r_lock && !req_valid[r_grant_id]) begin
                        r_lock   <= 1'b0;
                        r_rr_ptr <= w_grant_next;
                    end
`endif
                    if (w_found) begin
                        r_state    <= ST_GRANT;
                        r_grant_id <= w_win;
                        r_reg_d    <= w_data;
                        r_ready    <= w_ready_oh;
                        r_reg_en   <= w_en_oh;
                        r_addr_err <= !w_addr_ok;
                        r_busy     <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    r_state    <= ST_IDLE;
                    r_ready    <= '0;
                    r_reg_en   <= '0;
                    r_addr_err <= 1'b0;
                    r_busy     <= 1'b0;
`ifdef REG_ARB_LOCK_EN
                    if (req_lock[r_grant_id]) begin
                        r_lock <= 1'b1;
                    end else begin
                        r_lock   <= 1'b0;
                        r_rr_ptr <= w_grant_next;
                    end
`else
                    r_rr_ptr   <= w_grant_next;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = r_ready;
    assign reg_en    = r_reg_en;
    assign reg_d     = r_reg_d;
    assign grant_id  = r_grant_id;
    assign busy      = r_busy;
    assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (4 requesters, 4 registers, 3-bit
// address so out-of-range targets can be driven). Lock steps run only when
// REG_ARB_LOCK_EN is defined.
module tb_reg_write_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int NUM_REGS = 4;
    localparam int AW       = 3;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ*AW-1:0] req_addr  = '0;
    logic [NUM_REQ*8-1:0]  req_data  = '0;
`ifdef REG_ARB_LOCK_EN
    logic [NUM_REQ-1:0]    req_lock  = '0;
`endif
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REGS-1:0]   reg_en;
    logic [7:0]            reg_d;
    logic [1:0]            grant_id;
    logic                  busy;
    logic                  addr_err;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] bank [NUM_REGS] = '{default: 8'h00};
    int         exp_order [5]   = '{0, 1, 2, 3, 0};
    int         rdy_cnt [NUM_REQ];

    reg_write_arbiter #(
        .NUM_REQ (NUM_REQ),
        .NUM_REGS(NUM_REGS),
        .AW      (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_data (req_data),
`ifdef REG_ARB_LOCK_EN
        .req_lock (req_lock),
`endif
        .req_ready(req_ready),
        .reg_en   (reg_en),
        .reg_d    (reg_d),
        .grant_id (grant_id),
        .busy     (busy),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    // Register bank as the arbiter's consumer sees it
    always @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_en[i]) bank[i] <= reg_d;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [7:0] d);
        req_valid[i]         = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_data[i*8 +: 8]   = d;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic chk_grant(input string tag, input int id, input logic [3:0] en, input logic [7:0] d, input logic err);
        chk({tag, "_gid"},   32'(grant_id),  32'(id));
        chk({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
        chk({tag, "_en"},    32'(reg_en),    32'(en));
        chk({tag, "_d"},     32'(reg_d),     32'(d));
        chk({tag, "_busy"},  32'(busy),      32'd1);
        chk({tag, "_aerr"},  32'(addr_err),  32'(err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not complete");
    end

    initial begin
        // Reset values while rst_n is held low
        #12;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_en",    32'(reg_en),    32'h0);
        chk("rst_d",     32'(reg_d),     32'h0);
        chk("rst_gid",   32'(grant_id),  32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_aerr",  32'(addr_err),  32'h0);
        rst_n = 1'b1;
        step();

        // All four requesters continuously valid: 0,1,2,3,0, one grant per 2 cycles
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, AW'(i), 8'(8'h10 + i));
            rdy_cnt[i] = 0;
        end
        for (int g = 0; g < 5; g++) begin
            step();
            chk("rr_gid",   32'(grant_id),  32'(exp_order[g]));
            chk("rr_ready", 32'(req_ready), 32'(1 << exp_order[g]));
            chk("rr_en",    32'(reg_en),    32'(1 << exp_order[g]));
            chk("rr_d",     32'(reg_d),     32'(8'h10 + exp_order[g]));
            if (g < 4) for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] += int'(req_ready[i]);
            step();
            chk("rr_gap_busy",  32'(busy),      32'h0);
            chk("rr_gap_ready", 32'(req_ready), 32'h0);
        end
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            chk("rr_once_per_8", 32'(rdy_cnt[i]), 32'd1);
            chk("rr_bank",       32'(bank[i]),    32'(8'h10 + i));
        end

        // Single request: requester 2 writes A5 to register 1 (rr_ptr is 1)
        set_req(2, 3'd1, 8'hA5);
        step();
        chk_grant("single", 2, 4'b0010, 8'hA5, 1'b0);
        step();
        chk("single_ready_off", 32'(req_ready), 32'h0);
        chk("single_en_off",    32'(reg_en),    32'h0);
        chk("single_busy_off",  32'(busy),      32'h0);
        chk("single_gid_hold",  32'(grant_id),  32'd2);
        chk("single_d_hold",    32'(reg_d),     32'hA5);
        chk("single_bank1",     32'(bank[1]),   32'hA5);
        clr_req(2);

        // Out-of-range target: requester 1 writes address 5 (rr_ptr is 3)
        set_req(1, 3'd5, 8'h3C);
        step();
        chk_grant("aerr", 1, 4'b0000, 8'h3C, 1'b1);
        step();
        chk("aerr_off",   32'(addr_err), 32'h0);
        chk("aerr_bank1", 32'(bank[1]),  32'hA5);
        clr_req(1);

        // Requesters 1 and 3: rr_ptr is now 2, so 3 wins before 1
        set_req(1, 3'd0, 8'h11);
        set_req(3, 3'd2, 8'h33);
        step();
        chk_grant("pair_first", 3, 4'b0100, 8'h33, 1'b0);
        step();
        clr_req(3);
        step();
        chk_grant("pair_second", 1, 4'b0001, 8'h11, 1'b0);
        step();
        clr_req(1);
        chk("pair_bank2", 32'(bank[2]), 32'h33);
        chk("pair_bank0", 32'(bank[0]), 32'h11);

        // Move rr_ptr to 3, then requesters 0 and 3 compete: 3 then 0
        set_req(2, 3'd3, 8'h22);
        step();
        chk_grant("prep", 2, 4'b1000, 8'h22, 1'b0);
        step();
        clr_req(2);
        set_req(0, 3'd0, 8'h0A);
        set_req(3, 3'd1, 8'h3B);
        step();
        chk_grant("wrap_first", 3, 4'b0010, 8'h3B, 1'b0);
        step();
        clr_req(3);
        step();
        chk_grant("wrap_second", 0, 4'b0001, 8'h0A, 1'b0);
        step();
        clr_req(0);

        // Asynchronous reset in the middle of a GRANT cycle (rr_ptr is 1)
        set_req(2, 3'd3, 8'h77);
        step();
        chk_grant("pre_rst", 2, 4'b1000, 8'h77, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(req_ready), 32'h0);
        chk("arst_en",    32'(reg_en),    32'h0);
        chk("arst_busy",  32'(busy),      32'h0);
        chk("arst_gid",   32'(grant_id),  32'h0);
        chk("arst_d",     32'(reg_d),     32'h0);
        set_req(0, 3'd2, 8'h55);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        chk("arst_no_write", 32'(bank[3]), 32'h22);
        chk_grant("post_rst_first", 0, 4'b0100, 8'h55, 1'b0);
        step();
        clr_req(0);
        step();
        chk_grant("post_rst_second", 2, 4'b1000, 8'h77, 1'b0);
        step();
        clr_req(2);
        chk("post_rst_bank3", 32'(bank[3]), 32'h77);
        chk("post_rst_bank2", 32'(bank[2]), 32'h55);

`ifdef REG_ARB_LOCK_EN
        // Requester 1 locks for three grants while requester 2 waits (rr_ptr is 3)
        set_req(1, 3'd0, 8'hC1);
        set_req(2, 3'd1, 8'hC2);
        req_lock[1] = 1'b1;
        step();
        chk_grant("lock_1", 1, 4'b0001, 8'hC1, 1'b0);
        step();
        step();
        chk_grant("lock_2", 1, 4'b0001, 8'hC1, 1'b0);
        step();
        step();
        chk_grant("lock_3", 1, 4'b0001, 8'hC1, 1'b0);
        req_lock[1] = 1'b0;
        step();
        step();
        chk_grant("lock_release", 2, 4'b0010, 8'hC2, 1'b0);
        step();
        req_valid = '0;
`endif

        step();
        chk("idle_busy", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
